rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single synchronous-read port of the 16K x 8 program/font ROM between two requesters:
//  the CPU (single-byte opcode and operand fetches) and the sprite engine (DXYN row bursts).
//  Sits between both requesters and the ROM; drives the ROM address and routes the returned byte.
//  ROM read latency is one clock: an address presented in cycle T returns data in T+1.
// PARAMETERS
//  AW  14  ROM address width
//  DW  8   ROM data width
// PORTS
//  clk         in   1   system clock, all logic on posedge
//  reset_n     in   1   asynchronous active-low reset
//  cpu_req     in   1   CPU requests a 1-byte read; held until cpu_gnt
//  cpu_addr    in   AW  CPU read address
//  cpu_gnt     out  1   comb: CPU address is issued to ROM this cycle
//  cpu_rvalid  out  1   reg: cpu_rdata valid (cycle after cpu_gnt)
//  cpu_rdata   out  DW  CPU read data (= mem_dout)
//  spr_req     in   1   sprite engine requests a burst; held until spr_gnt
//  spr_addr    in   AW  burst base address (I register)
//  spr_len     in   4   burst length in bytes; 0 encodes 16
//  spr_gnt     out  1   comb: burst accepted, byte 0 issued this cycle
//  spr_rvalid  out  1   reg: spr_rdata valid
//  spr_rdata   out  DW  sprite row data (= mem_dout)
//  spr_done    out  1   reg: pulses with the last spr_rvalid of a burst
//  mem_addr    out  AW  comb: address to ROM addr port
//  mem_dout    in   DW  ROM data output
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE, all rvalid/done low, burst counter 0, last-grant = SPR;
//    mem_addr = 0 while in reset; gnt outputs low while in reset.
//  - States: IDLE, BURST.
//  - IDLE: arbitrate among cpu_req/spr_req each cycle; winner gets gnt the same cycle and
//    mem_addr = winner address. No request: mem_addr holds previous value, no gnt.
//    CPU grant: stay IDLE (CPU may be granted every cycle, back-to-back).
//    SPR grant: latch base+1 and remaining=len-1 (len 0 -> 16); if remaining=0 stay IDLE, else -> BURST.
//  - BURST: mem_addr = latched address; increment address, decrement remaining each cycle;
//    remaining reaches 0 -> IDLE same edge. No gnt asserted in BURST; bursts are never interrupted;
//    CPU request waits. Burst of N bytes occupies exactly N consecutive issue cycles.
//  - Responses: rvalid registered from issue cycle: X_rvalid(T+1) = issued_for_X(T). rdata is
//    mem_dout unregistered; spr_done(T+1) = last byte of burst issued at T.
//  - Address arithmetic modulo 2^AW: 0x3FFF + 1 -> 0x0000 within a burst.
//  - Simultaneous request in IDLE resolved per CONFIGURATION. A burst completing in the same
//    cycle a new request arrives: the new request is arbitrated in the next cycle (first IDLE cycle).
//  - Reset mid-burst: burst aborted; no further rvalid or spr_done; requester must re-request.
//  - Requester dropping req without gnt: legal, no side effects.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not granted last;
//    last-grant updates on every gnt (CPU grant -> SPR favoured next; burst -> CPU favoured next).
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, CPU always wins; last-grant register absent;
//    continuous cpu_req starves spr_req (accepted: CPU interpreter stalls between fetches).
// TESTING
//  1 reset_n=0 mid-run -> all gnt/rvalid/done 0, mem_addr 0; release -> IDLE, no spurious rvalid.
//  2 cpu_req, cpu_addr=0x000 -> cpu_gnt same cycle, next cycle cpu_rvalid=1, cpu_rdata=0xF0.
//  3 spr_req, addr=0x000, len=5 -> 5 consecutive spr_rvalid with F0,90,90,90,F0; spr_done on 5th; cpu_req held during burst granted first IDLE cycle after.
//  4 spr_addr=0x3FFE, len=4 -> mem_addr 3FFE,3FFF,0000,0001 on consecutive cycles; len=0 -> 16 bytes.
//  5 cpu_req and spr_req both held: no macro -> CPU granted every cycle, spr never;
//    ARB_ROUND_ROBIN_EN -> CPU, burst, CPU, burst alternation.
//  6 reset_n asserted on 3rd byte of a len=8 burst -> no further spr_rvalid, spr_done never pulses.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Arbitrates the single synchronous-read ROM port between CPU byte fetches and sprite row bursts.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed CPU priority.
module rom_port_arbiter #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          spr_req,
    input  logic [AW-1:0] spr_addr,
    input  logic [3:0]    spr_len,
    output logic          spr_gnt,
    output logic          spr_rvalid,
    output logic [DW-1:0] spr_rdata,
    output logic          spr_done,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout
);

    localparam int unsigned LW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [AW-1:0] hold_q;
    logic          cpu_rvalid_q;
    logic          spr_rvalid_q;
    logic          spr_done_q;
    logic          cpu_win_c;
    logic          spr_iss_c;
    logic          last_iss_c;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_spr_q, last_spr_d;

    // On contention the CPU wins only if the sprite engine was granted last.
    assign cpu_win_c = cpu_req & (~spr_req | last_spr_q);

    always_comb begin
        last_spr_d = last_spr_q;
        if (cpu_gnt) begin
            last_spr_d = 1'b0;
        end else if (spr_gnt) begin
            last_spr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_spr_q <= 1'b1;
        end else begin
            last_spr_q <= last_spr_d;
        end
    end
`else
    assign cpu_win_c = cpu_req;
`endif

    // Arbitration, burst sequencing and ROM address selection.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        mem_addr   = hold_q;
        cpu_gnt    = 1'b0;
        spr_gnt    = 1'b0;
        spr_iss_c  = 1'b0;
        last_iss_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (reset_n) begin
                    if (cpu_win_c) begin
                        cpu_gnt  = 1'b1;
                        mem_addr = cpu_addr;
                    end else if (spr_req) begin
                        spr_gnt   = 1'b1;
                        spr_iss_c = 1'b1;
                        mem_addr  = spr_addr;
                        addr_d    = spr_addr + AW'(1);
                        // A length of 0 wraps to 15 remaining, i.e. a 16-byte burst.
                        rem_d     = spr_len - LW'(1);
                        if (rem_d == LW'(0)) begin
                            last_iss_c = 1'b1;
                        end else begin
                            state_d = BURST;
                        end
                    end
                end
            end
            BURST: begin
                mem_addr  = addr_q;
                addr_d    = addr_q + AW'(1);
                rem_d     = rem_q - LW'(1);
                spr_iss_c = 1'b1;
                if (rem_q == LW'(1)) begin
                    last_iss_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            hold_q       <= '0;
            cpu_rvalid_q <= 1'b0;
            spr_rvalid_q <= 1'b0;
            spr_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            hold_q       <= mem_addr;
            cpu_rvalid_q <= cpu_gnt;
            spr_rvalid_q <= spr_iss_c;
            spr_done_q   <= last_iss_c;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign spr_rvalid = spr_rvalid_q;
    assign spr_done   = spr_done_q;
    assign cpu_rdata  = mem_dout;
    assign spr_rdata  = mem_dout;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed vector table, then random traffic against a queue-based model.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic [13:0] cpu_addr;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        spr_req;
    logic [13:0] spr_addr;
    logic [3:0]  spr_len;
    logic        spr_gnt;
    logic        spr_rvalid;
    logic [7:0]  spr_rdata;
    logic        spr_done;
    logic [13:0] mem_addr;
    logic [7:0]  mem_dout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.AW(14), .DW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_len(spr_len), .spr_gnt(spr_gnt),
        .spr_rvalid(spr_rvalid), .spr_rdata(spr_rdata), .spr_done(spr_done),
        .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    // ROM contents: font digit "0" at 0..4, a scrambled pattern elsewhere.
    function automatic logic [7:0] rom_byte(input logic [13:0] a);
        int unsigned v;
        v = 32'(a);
        case (a)
            14'h0000, 14'h0004: return 8'hF0;
            14'h0001, 14'h0002, 14'h0003: return 8'h90;
            default: return 8'((v * 13 + 7) ^ (v >> 6));
        endcase
    endfunction

    always @(posedge clk) mem_dout <= rom_byte(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic        cr;
        logic [13:0] ca;
        logic        sr;
        logic [13:0] sa;
        logic [3:0]  sl;
        logic        gc;
        logic        gs;
        logic [13:0] ma;
        logic        crv;
        logic        srv;
        logic        dn;
        logic [7:0]  d;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic cr, input logic [13:0] ca,
                                input logic sr, input logic [13:0] sa, input logic [3:0] sl,
                                input logic gc, input logic gs, input logic [13:0] ma,
                                input logic crv, input logic srv, input logic dn,
                                input logic [7:0] d);
        vec_t v;
        v.r = r; v.cr = cr; v.ca = ca; v.sr = sr; v.sa = sa; v.sl = sl;
        v.gc = gc; v.gs = gs; v.ma = ma; v.crv = crv; v.srv = srv; v.dn = dn; v.d = d;
        return v;
    endfunction

    // Reference model: a burst grant expands into a queue of future sprite addresses.
    typedef struct packed {
        logic [13:0] addr;
        logic        last;
    } beat_t;

    beat_t       m_q[$];
    logic        m_last_cpu;
    logic [13:0] m_hold;
    logic        m_prev_cpu, m_prev_spr, m_prev_done;
    logic [13:0] m_prev_addr;
    logic        e_cgnt, e_sgnt, e_crv, e_srv, e_done;
    logic [13:0] e_mem;
    logic [7:0]  e_data;

    task automatic model_step();
        beat_t b;
        int    n;
        logic  cpu_first;
        if (!reset_n) begin
            m_q.delete();
            m_last_cpu = 1'b0; m_hold = '0; m_prev_addr = '0;
            m_prev_cpu = 1'b0; m_prev_spr = 1'b0; m_prev_done = 1'b0;
            e_cgnt = 1'b0; e_sgnt = 1'b0; e_mem = '0;
            e_crv = 1'b0; e_srv = 1'b0; e_done = 1'b0; e_data = '0;
            return;
        end
`ifdef ARB_ROUND_ROBIN_EN
        cpu_first = !m_last_cpu;
`else
        cpu_first = 1'b1;
`endif
        e_crv  = m_prev_cpu;
        e_srv  = m_prev_spr;
        e_done = m_prev_done;
        e_data = rom_byte(m_prev_addr);
        e_cgnt = 1'b0; e_sgnt = 1'b0;
        m_prev_cpu = 1'b0; m_prev_spr = 1'b0; m_prev_done = 1'b0;
        if (m_q.size() > 0) begin
            b = m_q.pop_front();
            e_mem = b.addr;
            m_prev_spr = 1'b1;
            m_prev_done = b.last;
        end else if (cpu_req && (!spr_req || cpu_first)) begin
            e_cgnt = 1'b1;
            e_mem = cpu_addr;
            m_prev_cpu = 1'b1;
            m_last_cpu = 1'b1;
        end else if (spr_req) begin
            n = (spr_len == 4'd0) ? 16 : int'(spr_len);
            e_sgnt = 1'b1;
            e_mem = spr_addr;
            m_prev_spr = 1'b1;
            m_prev_done = (n == 1);
            m_last_cpu = 1'b0;
            for (int k = 1; k < n; k++) begin
                b.addr = 14'(32'(spr_addr) + k);
                b.last = (k == n - 1);
                m_q.push_back(b);
            end
        end else begin
            e_mem = m_hold;
        end
        m_hold = e_mem;
        m_prev_addr = e_mem;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " cpu_gnt"}, 32'(cpu_gnt), 32'(e_cgnt));
        chk({tag, " spr_gnt"}, 32'(spr_gnt), 32'(e_sgnt));
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'(e_mem));
        chk({tag, " cpu_rvalid"}, 32'(cpu_rvalid), 32'(e_crv));
        chk({tag, " spr_rvalid"}, 32'(spr_rvalid), 32'(e_srv));
        chk({tag, " spr_done"}, 32'(spr_done), 32'(e_done));
        if (e_crv) chk({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'(e_data));
        if (e_srv) chk({tag, " spr_rdata"}, 32'(spr_rdata), 32'(e_data));
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        string tg;
        int   rst_left;

        reset_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
        spr_req = 1'b0; spr_addr = '0; spr_len = '0;

        // r cr ca sr sa sl | gc gs ma crv srv dn d
        tbl.push_back(mk(0, 1, 14'h005, 1, 14'h000, 4'd5, 0, 0, 14'h0000, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0000, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 14'h000, 0, 14'h000, 4'd0, 1, 0, 14'h0000, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0000, 1, 0, 0, 8'hF0));
        tbl.push_back(mk(1, 1, 14'h123, 0, 14'h000, 4'd0, 1, 0, 14'h0123, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 14'h124, 0, 14'h000, 4'd0, 1, 0, 14'h0124, 1, 0, 0, rom_byte(14'h123)));
        tbl.push_back(mk(1, 0, 14'h000, 1, 14'h000, 4'd5, 0, 1, 14'h0000, 1, 0, 0, rom_byte(14'h124)));
        tbl.push_back(mk(1, 1, 14'h200, 0, 14'h000, 4'd0, 0, 0, 14'h0001, 0, 1, 0, 8'hF0));
        tbl.push_back(mk(1, 1, 14'h200, 0, 14'h000, 4'd0, 0, 0, 14'h0002, 0, 1, 0, 8'h90));
        tbl.push_back(mk(1, 1, 14'h200, 0, 14'h000, 4'd0, 0, 0, 14'h0003, 0, 1, 0, 8'h90));
        tbl.push_back(mk(1, 1, 14'h200, 0, 14'h000, 4'd0, 0, 0, 14'h0004, 0, 1, 0, 8'h90));
        tbl.push_back(mk(1, 1, 14'h200, 0, 14'h000, 4'd0, 1, 0, 14'h0200, 0, 1, 1, 8'hF0));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0200, 1, 0, 0, rom_byte(14'h200)));
        tbl.push_back(mk(1, 0, 14'h000, 1, 14'h3FFE, 4'd4, 0, 1, 14'h3FFE, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h3FFF, 0, 1, 0, rom_byte(14'h3FFE)));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0000, 0, 1, 0, rom_byte(14'h3FFF)));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0001, 0, 1, 0, 8'hF0));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0001, 0, 1, 1, 8'h90));
        tbl.push_back(mk(1, 0, 14'h000, 1, 14'h050, 4'd1, 0, 1, 14'h0050, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0050, 0, 1, 1, rom_byte(14'h050)));
        // len 0 means 16 bytes, wrapping from 0x3FFF to 0x0000
        tbl.push_back(mk(1, 0, 14'h000, 1, 14'h3FF8, 4'd0, 0, 1, 14'h3FF8, 0, 0, 0, 8'h00));
        for (int k = 1; k < 16; k++) begin
            tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'(14'h3FF8 + k),
                             0, 1, 0, rom_byte(14'(14'h3FF8 + k - 1))));
        end
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0007, 0, 1, 1, rom_byte(14'h0007)));
        // both requesting
        tbl.push_back(mk(1, 1, 14'h300, 1, 14'h010, 4'd2, 1, 0, 14'h0300, 0, 0, 0, 8'h00));
`ifdef ARB_ROUND_ROBIN_EN
        tbl.push_back(mk(1, 1, 14'h300, 1, 14'h010, 4'd2, 0, 1, 14'h0010, 1, 0, 0, rom_byte(14'h300)));
        tbl.push_back(mk(1, 1, 14'h300, 1, 14'h010, 4'd2, 0, 0, 14'h0011, 0, 1, 0, rom_byte(14'h010)));
        tbl.push_back(mk(1, 1, 14'h300, 1, 14'h010, 4'd2, 1, 0, 14'h0300, 0, 1, 1, rom_byte(14'h011)));
        tbl.push_back(mk(1, 1, 14'h300, 1, 14'h010, 4'd2, 0, 1, 14'h0010, 1, 0, 0, rom_byte(14'h300)));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0011, 0, 1, 0, rom_byte(14'h010)));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0011, 0, 1, 1, rom_byte(14'h011)));
`else
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(1, 1, 14'h300, 1, 14'h010, 4'd2, 1, 0, 14'h0300, 1, 0, 0, rom_byte(14'h300)));
        end
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0300, 1, 0, 0, rom_byte(14'h300)));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0300, 0, 0, 0, 8'h00));
`endif
        // reset lands on the third byte of an 8-byte burst
        tbl.push_back(mk(1, 0, 14'h000, 1, 14'h100, 4'd8, 0, 1, 14'h0100, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0101, 0, 1, 0, rom_byte(14'h100)));
        tbl.push_back(mk(0, 1, 14'h055, 0, 14'h000, 4'd0, 0, 0, 14'h0000, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0000, 0, 0, 0, 8'h00));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0000, 0, 0, 0, 8'h00));
        end
        tbl.push_back(mk(1, 1, 14'h007, 0, 14'h000, 4'd0, 1, 0, 14'h0007, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 14'h000, 0, 14'h000, 4'd0, 0, 0, 14'h0007, 1, 0, 0, rom_byte(14'h007)));

        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            v = tbl[i];
            @(posedge clk);
            #1;
            reset_n = v.r; cpu_req = v.cr; cpu_addr = v.ca;
            spr_req = v.sr; spr_addr = v.sa; spr_len = v.sl;
            @(negedge clk);
            tg = $sformatf("vec%0d", i);
            chk({tg, " cpu_gnt"}, 32'(cpu_gnt), 32'(v.gc));
            chk({tg, " spr_gnt"}, 32'(spr_gnt), 32'(v.gs));
            chk({tg, " mem_addr"}, 32'(mem_addr), 32'(v.ma));
            chk({tg, " cpu_rvalid"}, 32'(cpu_rvalid), 32'(v.crv));
            chk({tg, " spr_rvalid"}, 32'(spr_rvalid), 32'(v.srv));
            chk({tg, " spr_done"}, 32'(spr_done), 32'(v.dn));
            if (v.crv) chk({tg, " cpu_rdata"}, 32'(cpu_rdata), 32'(v.d));
            if (v.srv) chk({tg, " spr_rdata"}, 32'(spr_rdata), 32'(v.d));
        end

        // Random traffic, with occasional resets, checked cycle by cycle against the model.
        e_cgnt = 1'b0; e_sgnt = 1'b0;
        rst_left = 2;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (rst_left == 0 && $urandom_range(0, 249) == 0) rst_left = int'($urandom_range(1, 3));
            reset_n = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            if (cpu_req && !e_cgnt && $urandom_range(0, 15) == 0) begin
                cpu_req = 1'b0;
            end else if (e_cgnt || !cpu_req) begin
                cpu_req  = ($urandom_range(0, 99) < 45);
                cpu_addr = 14'($urandom);
            end
            if (spr_req && !e_sgnt && $urandom_range(0, 15) == 0) begin
                spr_req = 1'b0;
            end else if (e_sgnt || !spr_req) begin
                spr_req  = ($urandom_range(0, 99) < 35);
                spr_addr = ($urandom_range(0, 3) == 0) ? 14'(32'h3FF0 + $urandom_range(0, 15))
                                                        : 14'($urandom);
                spr_len  = 4'($urandom);
            end
            @(negedge clk);
            model_step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
